// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-divider ratio controller and its benches.
package clk_div_pkg;

    localparam int unsigned LEGAL_CHECK_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        SETTLE    = 2'd2
    } ctrl_state_e;

    // A divider ratio is usable when it is even and at least 2.
    function automatic logic ratio_is_legal(input logic [LEGAL_CHECK_W-1:0] ratio);
        return (ratio[0] == 1'b0) && (ratio >= LEGAL_CHECK_W'(2));
    endfunction

endpackage

// File: rtl/clk_edge_det.sv
// Samples a slow clock as data and flags its rising edges in the fast domain.
module clk_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise_c
);

    logic prev_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= i_sig;
        end
    end

    assign o_rise_c = i_sig & ~prev_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Ratio/enable update controller for the even clock divider; applies changes
// only at divided-clock rising edges so the divider never emits a runt pulse.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned RATIO_WIDTH    = 8,
    parameter int unsigned RESET_RATIO    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_req_valid,
    input  logic [RATIO_WIDTH-1:0] i_req_ratio,
    input  logic                   i_req_en,
    output logic                   o_req_ready,
    input  logic                   i_div_clk,
    output logic [RATIO_WIDTH-1:0] o_div_ratio,
    output logic                   o_div_en,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic                   o_timeout
);

    localparam int unsigned          CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RATIO_WIDTH-1:0] RST_RATIO = RATIO_WIDTH'(RESET_RATIO);

    ctrl_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RATIO_WIDTH-1:0] pend_ratio_q, pend_ratio_d;
    logic                   pend_en_q, pend_en_d;
    logic [RATIO_WIDTH-1:0] ratio_d;
    logic                   en_d;
    logic                   done_d, err_d, tmo_d;

    logic                   div_rise_c;
    logic                   accept_c;
    logic                   req_legal_c;
    logic [RATIO_WIDTH-1:0] req_ratio_eff_c;
    logic                   immediate_c;
    logic                   timeout_hit_c;

    clk_edge_det u_edge_det (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_sig    (i_div_clk),
        .o_rise_c (div_rise_c)
    );

    // Request decode; a disable keeps the current ratio on the divider.
    always_comb begin
        accept_c        = i_req_valid & o_req_ready;
        req_legal_c     = !i_req_en || ratio_is_legal(LEGAL_CHECK_W'(i_req_ratio));
        req_ratio_eff_c = i_req_en ? i_req_ratio : o_div_ratio;
        immediate_c     = !o_div_en ||
                          ((req_ratio_eff_c == o_div_ratio) && (i_req_en == o_div_en));
        timeout_hit_c   = (cnt_q == CNT_LAST);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c && req_legal_c && !immediate_c) begin
                    state_d = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (div_rise_c || timeout_hit_c) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!o_div_en || div_rise_c || timeout_hit_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; an edge always takes priority over timeout.
    always_comb begin
        ratio_d      = o_div_ratio;
        en_d         = o_div_en;
        pend_ratio_d = pend_ratio_q;
        pend_en_d    = pend_en_q;
        cnt_d        = timeout_hit_c ? cnt_q : cnt_q + CNT_W'(1);
        done_d       = 1'b0;
        err_d        = 1'b0;
        tmo_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept_c) begin
                    if (!req_legal_c) begin
                        err_d = 1'b1;
                    end else if (immediate_c) begin
                        ratio_d = req_ratio_eff_c;
                        en_d    = i_req_en;
                        done_d  = 1'b1;
                    end else begin
                        pend_ratio_d = req_ratio_eff_c;
                        pend_en_d    = i_req_en;
                    end
                end
            end
            WAIT_EDGE: begin
                if (div_rise_c || timeout_hit_c) begin
                    ratio_d = pend_ratio_q;
                    en_d    = pend_en_q;
                    done_d  = 1'b1;
                    tmo_d   = !div_rise_c;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (!div_rise_c && timeout_hit_c) begin
                    tmo_d = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Registered outputs and datapath state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_div_ratio  <= RST_RATIO;
            o_div_en     <= 1'b0;
            o_req_ready  <= 1'b1;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_timeout    <= 1'b0;
            pend_ratio_q <= RST_RATIO;
            pend_en_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            o_div_ratio  <= ratio_d;
            o_div_en     <= en_d;
            o_req_ready  <= (state_d == IDLE);
            o_busy       <= (state_d != IDLE);
            o_done       <= done_d;
            o_err        <= err_d;
            o_timeout    <= tmo_d;
            pend_ratio_q <= pend_ratio_d;
            pend_en_q    <= pend_en_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl; the divided clock is driven by hand.
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [7:0] req_ratio;
    logic       req_en;
    logic       req_ready;
    logic       div_clk;
    logic [7:0] div_ratio;
    logic       div_en;
    logic       busy;
    logic       done;
    logic       err;
    logic       tmo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .RATIO_WIDTH    (8),
        .RESET_RATIO    (2),
        .TIMEOUT_CYCLES (512)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_ratio (req_ratio),
        .i_req_en    (req_en),
        .o_req_ready (req_ready),
        .i_div_clk   (div_clk),
        .o_div_ratio (div_ratio),
        .o_div_en    (div_en),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_timeout   (tmo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] r, input logic e);
        req_valid = 1'b1;
        req_ratio = r;
        req_en    = e;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_ratio = '0; req_en = 1'b0; div_clk = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (div_ratio !== 8'd2) begin bad++; $display("FAIL rst_ratio got=%0d exp=2", div_ratio); end
        total++;
        if ({div_en, req_ready, busy} !== 3'b010) begin bad++; $display("FAIL rst_en_rdy_busy got=%b exp=010", {div_en, req_ready, busy}); end
        total++;
        if ({done, err, tmo} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b exp=000", {done, err, tmo}); end
    endtask

    task automatic test_immediate();
        send(8'd8, 1'b1);
        total++;
        if ({div_en, div_ratio} !== {1'b1, 8'd8}) begin bad++; $display("FAIL imm_out got en=%b r=%0d exp en=1 r=8", div_en, div_ratio); end
        total++;
        if ({done, req_ready, busy} !== 3'b110) begin bad++; $display("FAIL imm_flags got=%b exp=110", {done, req_ready, busy}); end
        tick();
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL imm_done_clear got=%b exp=0", done); end
    endtask

    task automatic test_illegal();
        logic [7:0] bad_r [2];
        bad_r[0] = 8'd5;
        bad_r[1] = 8'd0;
        for (int i = 0; i < 2; i++) begin
            send(bad_r[i], 1'b1);
            total++;
            if ({err, done, req_ready} !== 3'b101) begin bad++; $display("FAIL illegal_flags r=%0d got=%b exp=101", bad_r[i], {err, done, req_ready}); end
            total++;
            if ({div_en, div_ratio} !== {1'b1, 8'd8}) begin bad++; $display("FAIL illegal_out r=%0d got en=%b r=%0d exp en=1 r=8", bad_r[i], div_en, div_ratio); end
            tick();
            total++;
            if ({err, busy} !== 2'b00) begin bad++; $display("FAIL illegal_after r=%0d got=%b exp=00", bad_r[i], {err, busy}); end
        end
    endtask

    task automatic test_ratio_change();
        div_clk = 1'b0;
        tick();
        send(8'd4, 1'b1);
        total++;
        if ({req_ready, busy, div_ratio} !== {1'b0, 1'b1, 8'd8}) begin bad++; $display("FAIL chg_accept got rdy=%b busy=%b r=%0d exp rdy=0 busy=1 r=8", req_ready, busy, div_ratio); end
        repeat (3) tick();
        total++;
        if ({done, div_ratio} !== {1'b0, 8'd8}) begin bad++; $display("FAIL chg_hold got done=%b r=%0d exp done=0 r=8", done, div_ratio); end
        div_clk = 1'b1;
        tick();
        total++;
        if ({done, req_ready, div_ratio} !== {1'b1, 1'b0, 8'd4}) begin bad++; $display("FAIL chg_apply got done=%b rdy=%b r=%0d exp done=1 rdy=0 r=4", done, req_ready, div_ratio); end
        div_clk = 1'b1; tick();
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL chg_done_clear got=%b exp=0", done); end
        div_clk = 1'b0; tick();
        tick();
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL chg_settle_rdy got=%b exp=0", req_ready); end
        div_clk = 1'b1;
        tick();
        total++;
        if ({req_ready, busy} !== 2'b10) begin bad++; $display("FAIL chg_back_idle got=%b exp=10", {req_ready, busy}); end
    endtask

    task automatic test_disable();
        send(8'd6, 1'b0);
        total++;
        if ({req_ready, div_en} !== 2'b01) begin bad++; $display("FAIL dis_accept got=%b exp=01", {req_ready, div_en}); end
        div_clk = 1'b0; tick();
        div_clk = 1'b1; tick();
        total++;
        if ({div_en, div_ratio, done, req_ready} !== {1'b0, 8'd4, 1'b1, 1'b0}) begin bad++; $display("FAIL dis_apply got en=%b r=%0d done=%b rdy=%b exp en=0 r=4 done=1 rdy=0", div_en, div_ratio, done, req_ready); end
        tick();
        total++;
        if ({req_ready, busy} !== 2'b10) begin bad++; $display("FAIL dis_idle got=%b exp=10", {req_ready, busy}); end
        send(8'd8, 1'b1);
        total++;
        if ({div_en, div_ratio, done, req_ready} !== {1'b1, 8'd8, 1'b1, 1'b1}) begin bad++; $display("FAIL reen got en=%b r=%0d done=%b rdy=%b exp en=1 r=8 done=1 rdy=1", div_en, div_ratio, done, req_ready); end
    endtask

    task automatic test_timeout();
        logic early;
        div_clk = 1'b0;
        send(8'd6, 1'b1);
        early = 1'b0;
        repeat (511) begin
            tick();
            if (div_ratio !== 8'd8 || done !== 1'b0) early = 1'b1;
        end
        total++;
        if (early !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b exp=0", early); end
        tick();
        total++;
        if ({div_ratio, done, tmo} !== {8'd6, 1'b1, 1'b1}) begin bad++; $display("FAIL tmo_force got r=%0d done=%b tmo=%b exp r=6 done=1 tmo=1", div_ratio, done, tmo); end
        early = 1'b0;
        repeat (511) begin
            tick();
            if (req_ready !== 1'b0) early = 1'b1;
        end
        total++;
        if (early !== 1'b0) begin bad++; $display("FAIL tmo_settle_early got=%b exp=0", early); end
        tick();
        total++;
        if ({req_ready, tmo, done} !== 3'b110) begin bad++; $display("FAIL tmo_settle got=%b exp=110", {req_ready, tmo, done}); end
        tick();
        total++;
        if (tmo !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", tmo); end
        // Edge arriving on the final count beats the timeout.
        send(8'd4, 1'b1);
        repeat (511) tick();
        div_clk = 1'b1;
        tick();
        total++;
        if ({div_ratio, done, tmo} !== {8'd4, 1'b1, 1'b0}) begin bad++; $display("FAIL tie got r=%0d done=%b tmo=%b exp r=4 done=1 tmo=0", div_ratio, done, tmo); end
        div_clk = 1'b0; tick();
        div_clk = 1'b1; tick();
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL tie_idle got=%b exp=1", req_ready); end
    endtask

    task automatic test_reset_mid();
        div_clk = 1'b0; tick();
        send(8'd8, 1'b1);
        tick();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
        rst_n   = 1'b0;
        div_clk = 1'b1;
        tick();
        total++;
        if ({div_ratio, div_en, req_ready, done, busy} !== {8'd2, 1'b0, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL mid_rst got r=%0d en=%b rdy=%b done=%b busy=%b exp r=2 en=0 rdy=1 done=0 busy=0", div_ratio, div_en, req_ready, done, busy); end
        rst_n = 1'b1;
        tick();
        total++;
        if ({div_ratio, div_en, done} !== {8'd2, 1'b0, 1'b0}) begin bad++; $display("FAIL mid_after got r=%0d en=%b done=%b exp r=2 en=0 done=0", div_ratio, div_en, done); end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_illegal();
        test_ratio_change();
        test_disable();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Ratio-update controller that sits directly upstream of the even clock divider and drives its ratio and enable inputs. It accepts ratio/enable change requests over a valid/ready handshake, rejects illegal ratios, and applies each accepted change only at a rising edge of the divided clock, so the divider never produces a runt pulse. It samples the divider's output clock as ordinary data in the same `i_clk` domain.

## Interface
Parameters:
- `RATIO_WIDTH`, 8: width of ratio fields; matches divider.
- `RESET_RATIO`, 2: ratio driven out of reset; must be even and ≥2.
- `TIMEOUT_CYCLES`, 512: max `i_clk` cycles to wait for a divided-clock edge; must exceed 2^RATIO_WIDTH.

Ports:
- `i_clk` in 1: single clock; all logic on its rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_req_valid` in 1: request present.
- `i_req_ratio` in RATIO_WIDTH: requested division ratio.
- `i_req_en` in 1: requested divider enable.
- `o_req_ready` out 1: controller can accept a request.
- `i_div_clk` in 1: divider output clock, sampled as data.
- `o_div_ratio` out RATIO_WIDTH: to divider ratio input.
- `o_div_en` out 1: to divider enable input.
- `o_busy` out 1: high while not in IDLE.
- `o_done` out 1: one-cycle pulse when new settings appear on outputs.
- `o_err` out 1: one-cycle pulse on rejected request.
- `o_timeout` out 1: one-cycle pulse when an update or settle was forced by timeout.

## Operation
- Reset values: `o_div_ratio`=RESET_RATIO, `o_div_en`=0, `o_req_ready`=1, `o_busy`/`o_done`/`o_err`/`o_timeout`=0, edge-history register=0, timeout counter=0, state IDLE.
- Handshake: transfer when `i_req_valid && o_req_ready`; `o_req_ready` = (state==IDLE). Requests while not ready are ignored; the requester holds them.
- Legality (enable requests only): ratio even and ≥2. Illegal with `i_req_en`=1 → `o_err` pulse next cycle, outputs unchanged, stays IDLE. Disable requests (`i_req_en`=0) skip the check; `o_div_ratio` is retained.
- Rising-edge detect: `i_div_clk`==1 and the previous sampled value==0.
- States:
  - IDLE: on legal accept, if `o_div_en`==0 or request equals current outputs → update outputs next cycle, `o_done` pulse, remain IDLE. Otherwise latch request into a pending register → WAIT_EDGE, clear counter.
  - WAIT_EDGE: on detected edge → load pending into outputs, `o_done`, → SETTLE, clear counter. When the counter reaches TIMEOUT_CYCLES-1 with no edge → load anyway, `o_done` + `o_timeout`, → SETTLE.
  - SETTLE: wait for the next detected edge (divider running new ratio) → IDLE. If the new `o_div_en`==0, go straight to IDLE after one cycle. Timeout → IDLE with `o_timeout` pulse.
- Edge and timeout in the same cycle: edge wins, no `o_timeout`.
- Reset mid-operation: pending request discarded, all outputs to reset values on that clock edge.

## Timing
- Detection in cycle N → `o_div_ratio`/`o_div_en` change and `o_done` high in cycle N+1.
- Immediate-path accept in cycle N → outputs and `o_done` in N+1; `o_req_ready` stays 1.
- Illegal accept in cycle N → `o_err` in N+1.
- Minimum time from accept to ready for a running divider: one edge wait plus one full new period.
- The counter saturates; width is clog2(TIMEOUT_CYCLES).

## Structure
- Package `clk_div_pkg`: state encoding (IDLE, WAIT_EDGE, SETTLE) and a ratio-legality function shared with the divider bench.
- One sub-module, `clk_edge_det`: registers `i_div_clk` and outputs a rising-edge pulse; it is reused by the divider bench monitor.

## Test plan
- Reset, then request ratio 8 with en=1 while disabled → `o_div_en`=1 and `o_div_ratio`=8 one cycle after accept, `o_done` pulses, ready stays 1.
- Divider running at ratio 8, request ratio 4 → ready drops; outputs change exactly one cycle after the next `i_div_clk` rise; ready returns after the next rise, 4 cycles later.
- Request ratio 5, then ratio 0 → `o_err` pulse each time; ratio stays 8; state stays IDLE.
- Hold `i_div_clk` at 0 with a pending change → forced update after 512 cycles with `o_done` and `o_timeout`.
- Assert `i_rst_n`=0 during WAIT_EDGE → the next cycle shows ratio 2, en 0, ready 1, and no `o_done`.
- Request en=0 while running → the disable is applied at an edge, the ratio is retained, and the controller returns to IDLE one cycle later.
